unified_mem_arb: RTL and testbench

- Parametrised single-port, byte-addressed unified instruction/data memory for the pipelined core.
- Two requesters share the one storage port through a round-robin arbiter with req/gnt/rvalid handshakes: instruction fetch (if_*) and load/store unit (d_*).
- Reads are registered (1-cycle latency) and sign/zero-extended per RV32 func3. Misaligned, out-of-range and illegal accesses raise a fault instead of corrupting memory.
- Arbitration replaces the earlier half-clock fetch/data phase scheme.

---
 rtl/unified_mem_arb.sv | 119 +++++++++++
 tb/tb_unified_mem_arb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arb.sv
// rtl/unified_mem_arb.sv - byte-addressed unified I/D memory with round-robin fetch/data arbitration
module unified_mem_arb #(
  parameter int    DEPTH_BYTES = 1024,
  parameter int    DATA_BASE   = 512,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_fault,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_func3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_fault
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic {OWNER_IF = 1'b0, OWNER_D = 1'b1} owner_t;

  owner_t      last_owner, last_owner_next;
  logic [7:0]  mem [DEPTH_BYTES];

  logic [31:0] ea;
  logic [2:0]  d_size;
  logic        d_illegal, d_misalign, d_oob, d_fault_c, if_fault_c;
  logic [AW-1:0] acc_base;
  logic [AW-1:0] idx [4];
  logic [31:0] rd_word, ld_ext;

  // Arbiter state: remembers who won last so contention alternates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_owner <= OWNER_D;
    else        last_owner <= last_owner_next;
  end

  always_comb begin
    last_owner_next = last_owner;
    if (if_gnt)     last_owner_next = OWNER_IF;
    else if (d_gnt) last_owner_next = OWNER_D;
  end

  always_comb begin
    if_gnt = if_req && (!d_req || last_owner == OWNER_D);
    d_gnt  = d_req  && (!if_req || last_owner == OWNER_IF);
  end

  // Data access decode and fault qualification
  always_comb begin
    ea        = 32'(DATA_BASE) + d_addr;
    d_size    = 3'd4;
    d_illegal = 1'b0;
    case (d_func3)
      3'b000, 3'b100: d_size = 3'd1;
      3'b001, 3'b101: d_size = 3'd2;
      3'b010:         d_size = 3'd4;
      default:        d_illegal = 1'b1;
    endcase
    if (d_we && d_func3[2]) d_illegal = 1'b1;
    d_misalign = (d_size == 3'd2 && ea[0]) || (d_size == 3'd4 && ea[1:0] != 2'b00);
    d_oob      = ({1'b0, ea} + {30'b0, d_size}) > 33'(DEPTH_BYTES);
    d_fault_c  = d_illegal || d_misalign || d_oob;
    if_fault_c = (if_addr[1:0] != 2'b00) || (({1'b0, if_addr} + 33'd4) > 33'(DEPTH_BYTES));
  end

  // Single storage port: the granted requester owns the address this cycle
  always_comb begin
    acc_base = if_gnt ? if_addr[AW-1:0] : ea[AW-1:0];
    for (int k = 0; k < 4; k++) idx[k] = acc_base + AW'(k);
    rd_word = {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};
  end

  always_comb begin
    case (d_func3)
      3'b000:  ld_ext = {{24{rd_word[7]}}, rd_word[7:0]};
      3'b001:  ld_ext = {{16{rd_word[15]}}, rd_word[15:0]};
      3'b100:  ld_ext = {24'b0, rd_word[7:0]};
      3'b101:  ld_ext = {16'b0, rd_word[15:0]};
      default: ld_ext = rd_word;
    endcase
  end

  // A store coinciding with reset assertion must not land
  always_ff @(posedge clk) begin
    if (rst_n && d_gnt && d_we && !d_fault_c) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < d_size) mem[idx[k]] <= d_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      if_fault  <= 1'b0;
      if_rdata  <= 32'b0;
      d_rvalid  <= 1'b0;
      d_fault   <= 1'b0;
      d_rdata   <= 32'b0;
    end else begin
      if_rvalid <= if_gnt;
      if_fault  <= if_gnt && if_fault_c;
      if_rdata  <= (if_gnt && !if_fault_c) ? rd_word : 32'b0;
      d_rvalid  <= d_gnt;
      d_fault   <= d_gnt && d_fault_c;
      d_rdata   <= (d_gnt && !d_we && !d_fault_c) ? ld_ext : 32'b0;
    end
  end

endmodule

// File: tb/tb_unified_mem_arb.sv
// tb/tb_unified_mem_arb.sv - scoreboard bench for unified_mem_arb
module tb_unified_mem_arb;

  typedef struct packed {
    logic        fault;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_fault;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_func3 = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid, d_fault;
  logic [31:0] d_rdata;

  int    n_tests = 0;
  int    n_fail  = 0;
  resp_t q_if[$];
  resp_t q_d[$];
  int    gnt_log[$];
  logic  m_owner;
  logic [7:0] m_mem [0:1023];

  unified_mem_arb #(.DEPTH_BYTES(1024), .DATA_BASE(512), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_fault(if_fault),
    .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_fault(d_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_d(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output resp_t r);
    logic [31:0] ea, w;
    logic [32:0] endx;
    int sz;
    logic bad;
    ea  = 32'd512 + addr;
    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endx = {1'b0, ea} + 33'(sz);
    if (endx > 33'd1024) bad = 1'b1;
    if (sz == 2 && ea[0]) bad = 1'b1;
    if (sz == 4 && ea[1:0] != 2'b00) bad = 1'b1;
    r.fault = bad;
    r.data  = '0;
    if (!bad) begin
      if (we) begin
        for (int k = 0; k < sz; k++) m_mem[ea[9:0] + 10'(k)] = wd[8*k +: 8];
      end else begin
        w = {m_mem[ea[9:0]+10'd3], m_mem[ea[9:0]+10'd2], m_mem[ea[9:0]+10'd1], m_mem[ea[9:0]]};
        case (f3)
          3'b000:  r.data = {{24{w[7]}}, w[7:0]};
          3'b001:  r.data = {{16{w[15]}}, w[15:0]};
          3'b100:  r.data = {24'b0, w[7:0]};
          3'b101:  r.data = {16'b0, w[15:0]};
          default: r.data = w;
        endcase
      end
    end
  endtask

  // Monitor: responses for last edge's grants, then grants about to be taken
  always @(negedge clk) begin
    resp_t r, e;
    logic eig, edg;
    if (!rst_n) begin
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_d_rdata", d_rdata, 0);
      q_if.delete();
      q_d.delete();
      gnt_log.delete();
      m_owner = 1'b1;
    end else begin
      chk("if_rvalid", if_rvalid, q_if.size() != 0);
      if (if_rvalid && q_if.size() != 0) begin
        e = q_if.pop_front();
        chk("if_rdata", if_rdata, e.data);
        chk("if_fault", if_fault, e.fault);
      end
      chk("d_rvalid", d_rvalid, q_d.size() != 0);
      if (d_rvalid && q_d.size() != 0) begin
        e = q_d.pop_front();
        chk("d_rdata", d_rdata, e.data);
        chk("d_fault", d_fault, e.fault);
      end
      eig = if_req && (!d_req || m_owner);
      edg = d_req && (!if_req || !m_owner);
      chk("if_gnt", if_gnt, eig);
      chk("d_gnt", d_gnt, edg);
      if (eig) begin
        m_owner = 1'b0;
        gnt_log.push_back(0);
        r.fault = (if_addr[1:0] != 2'b00) || (({1'b0, if_addr} + 33'd4) > 33'd1024);
        r.data  = r.fault ? 32'b0 :
                  {m_mem[if_addr[9:0]+10'd3], m_mem[if_addr[9:0]+10'd2],
                   m_mem[if_addr[9:0]+10'd1], m_mem[if_addr[9:0]]};
        q_if.push_back(r);
      end else if (edg) begin
        m_owner = 1'b1;
        gnt_log.push_back(1);
        model_d(d_we, d_func3, d_addr, d_wdata, r);
        q_d.push_back(r);
      end
    end
  end

  task automatic d_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd);
    int n;
    d_we = we; d_func3 = f3; d_addr = addr; d_wdata = wd; d_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_gnt && n < 20);
    if (!d_gnt) chk("d_gnt_timeout", 0, 1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic if_op(input logic [31:0] addr);
    int n;
    if_addr = addr; if_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_gnt && n < 20);
    if (!if_gnt) chk("if_gnt_timeout", 0, 1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic reset_pulse(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    d_op(1, 3'b010, 0, 32'h0000_0011);
    d_op(0, 3'b010, 0, 0);
    d_op(1, 3'b010, 16, 32'h8000_80F0);
    d_op(0, 3'b000, 16, 0);
    d_op(0, 3'b100, 16, 0);
    d_op(0, 3'b001, 16, 0);
    d_op(0, 3'b101, 16, 0);
    d_op(1, 3'b010, 4, 32'h1122_3344);
    d_op(1, 3'b000, 5, 32'h0000_00AB);
    d_op(0, 3'b010, 4, 0);
    d_op(1, 3'b010, 508, 32'h5A5A_1234);
    d_op(0, 3'b010, 2, 0);
    d_op(0, 3'b001, 1, 0);
    d_op(1, 3'b010, 510, 32'hDEAD_BEEF);
    d_op(0, 3'b011, 0, 0);
    d_op(1, 3'b100, 8, 32'hFFFF_FFFF);
    d_op(0, 3'b001, 32'hFFFF_FDFE, 0);
    d_op(0, 3'b010, 0, 0);
    d_op(0, 3'b010, 508, 0);
    d_op(0, 3'b101, 510, 0);
    if_op(32'h0000_03FE);
    if_op(32'h0000_0210);
    if_op(32'h0000_03FC);

    reset_pulse(2);
    if_addr = 32'h0000_0210; d_we = 1'b0; d_func3 = 3'b010; d_addr = 16;
    if_req = 1'b1; d_req = 1'b1;
    repeat (6) @(posedge clk);
    #1 if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);
    chk("arb_grants", gnt_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < gnt_log.size()) chk($sformatf("arb_order%0d", i), gnt_log[i], i % 2);

    #1 d_op(1, 3'b010, 32, 32'hCAFE_F00D);
    rst_n = 1'b0;
    #1 chk("rst_async_d_rvalid", d_rvalid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    d_addr = 32; d_func3 = 3'b010; d_we = 1'b0; if_addr = 32'h0000_0200;
    if_req = 1'b1; d_req = 1'b1;
    @(posedge clk); #1 if_req = 1'b0; d_req = 1'b0;
    chk("post_rst_first_owner", (gnt_log.size() > 0) ? gnt_log[0] : 2, 0);
    d_op(0, 3'b010, 32, 0);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", q_if.size() + q_d.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
